// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues LW/LB/SB/SW on a req/ack bus, stalls EX while an access is
// outstanding, and holds the MEM/WB register for both memory and pass-through results.
module mem_access_stage #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid_i,
    input  logic [2:0]  ex_alu_sel_i,
    input  logic [7:0]  ex_alu_op_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_store_data_i,
    input  logic        ex_wreg_i,
    input  logic [4:0]  ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    output logic        stall_o,
    output logic        wb_valid_o,
    output logic        wb_wreg_o,
    output logic [4:0]  wb_waddr_o,
    output logic [31:0] wb_wdata_o,
    output logic        mem_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    localparam logic [2:0] RES_LOAD_STORE = 3'd6;
    localparam logic [7:0] LW_OP = 8'd10;
    localparam logic [7:0] LB_OP = 8'd11;
    localparam logic [7:0] SB_OP = 8'd12;
    localparam logic [7:0] SW_OP = 8'd13;
    localparam int CNT_W = $clog2(BUS_TIMEOUT + 2);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wb_valid_q, wb_valid_d;
    logic               wb_wreg_q, wb_wreg_d;
    logic [4:0]         wb_waddr_q, wb_waddr_d;
    logic [31:0]        wb_wdata_q, wb_wdata_d;
    logic               mem_err_q, mem_err_d;
    logic               bus_req_q, bus_req_d;
    logic               bus_we_q, bus_we_d;
    logic [31:0]        bus_addr_q, bus_addr_d;
    logic [3:0]         bus_be_q, bus_be_d;
    logic [31:0]        bus_wdata_q, bus_wdata_d;
    // Fields of the accepted load/store needed at retirement.
    logic               lat_lb_q, lat_lb_d;
    logic               lat_load_q, lat_load_d;
    logic [1:0]         lat_boff_q, lat_boff_d;
    logic               lat_wreg_q, lat_wreg_d;
    logic [4:0]         lat_waddr_q, lat_waddr_d;

    logic        is_ls, is_word, is_store, misaligned, timeout_hit;
    logic [7:0]  lb_byte;

    assign is_ls       = ex_valid_i && (ex_alu_sel_i == RES_LOAD_STORE) &&
                         (ex_alu_op_i >= LW_OP) && (ex_alu_op_i <= SW_OP);
    assign is_word     = (ex_alu_op_i == LW_OP) || (ex_alu_op_i == SW_OP);
    assign is_store    = (ex_alu_op_i == SB_OP) || (ex_alu_op_i == SW_OP);
    assign misaligned  = is_word && (ex_addr_i[1:0] != 2'b00);
    assign timeout_hit = (BUS_TIMEOUT > 0) && (cnt_q == TMO_LAST);
    assign lb_byte     = bus_rdata_i[{lat_boff_q, 3'b000} +: 8];

    assign stall_o = ((state_q == IDLE) && is_ls && !misaligned) ||
                     ((state_q == BUSY) && !bus_ack_i && !timeout_hit);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wb_valid_d  = 1'b0;
        wb_wreg_d   = 1'b0;
        wb_waddr_d  = wb_waddr_q;
        wb_wdata_d  = wb_wdata_q;
        mem_err_d   = 1'b0;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        lat_lb_d    = lat_lb_q;
        lat_load_d  = lat_load_q;
        lat_boff_d  = lat_boff_q;
        lat_wreg_d  = lat_wreg_q;
        lat_waddr_d = lat_waddr_q;
        case (state_q)
            IDLE: begin
                bus_req_d = 1'b0;
                if (ex_valid_i && !is_ls) begin
                    wb_valid_d = 1'b1;
                    wb_wreg_d  = ex_wreg_i;
                    wb_waddr_d = ex_waddr_i;
                    wb_wdata_d = ex_wdata_i;
                end else if (is_ls && misaligned) begin
                    wb_valid_d = 1'b1;
                    mem_err_d  = 1'b1;
                    wb_waddr_d = ex_waddr_i;
                end else if (is_ls) begin
                    state_d     = BUSY;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = is_store;
                    bus_addr_d  = {ex_addr_i[31:2], 2'b00};
                    bus_be_d    = is_word ? 4'hF : (4'b0001 << ex_addr_i[1:0]);
                    bus_wdata_d = (ex_alu_op_i == SB_OP) ? {4{ex_store_data_i[7:0]}}
                                                         : ex_store_data_i;
                    lat_lb_d    = (ex_alu_op_i == LB_OP);
                    lat_load_d  = !is_store;
                    lat_boff_d  = ex_addr_i[1:0];
                    lat_wreg_d  = ex_wreg_i;
                    lat_waddr_d = ex_waddr_i;
                end
            end
            BUSY: begin
                if (bus_ack_i) begin
                    state_d    = IDLE;
                    bus_req_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_wreg_d  = lat_load_q && lat_wreg_q;
                    wb_waddr_d = lat_waddr_q;
                    wb_wdata_d = lat_lb_q ? {{24{lb_byte[7]}}, lb_byte} : bus_rdata_i;
                end else if (timeout_hit) begin
                    state_d    = IDLE;
                    bus_req_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    mem_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wb_valid_q  <= 1'b0;
            wb_wreg_q   <= 1'b0;
            wb_waddr_q  <= '0;
            wb_wdata_q  <= '0;
            mem_err_q   <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            lat_lb_q    <= 1'b0;
            lat_load_q  <= 1'b0;
            lat_boff_q  <= '0;
            lat_wreg_q  <= 1'b0;
            lat_waddr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wb_valid_q  <= wb_valid_d;
            wb_wreg_q   <= wb_wreg_d;
            wb_waddr_q  <= wb_waddr_d;
            wb_wdata_q  <= wb_wdata_d;
            mem_err_q   <= mem_err_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            lat_lb_q    <= lat_lb_d;
            lat_load_q  <= lat_load_d;
            lat_boff_q  <= lat_boff_d;
            lat_wreg_q  <= lat_wreg_d;
            lat_waddr_q <= lat_waddr_d;
        end
    end

    assign wb_valid_o  = wb_valid_q;
    assign wb_wreg_o   = wb_wreg_q;
    assign wb_waddr_o  = wb_waddr_q;
    assign wb_wdata_o  = wb_wdata_q;
    assign mem_err_o   = mem_err_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_be_o    = bus_be_q;
    assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised bench for mem_access_stage: each transaction's stall count, bus request,
// and writeback are predicted from the stage's rules and compared after retirement.
module tb_mem_access_stage;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid_i;
    logic [2:0]  ex_alu_sel_i;
    logic [7:0]  ex_alu_op_i;
    logic [31:0] ex_addr_i;
    logic [31:0] ex_store_data_i;
    logic        ex_wreg_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        stall_o;
    logic        wb_valid_o;
    logic        wb_wreg_o;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o;
    logic        mem_err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    int vectors = 0;
    int errs = 0;
    int txn = 0;

    mem_access_stage #(.BUS_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid_i(ex_valid_i), .ex_alu_sel_i(ex_alu_sel_i), .ex_alu_op_i(ex_alu_op_i),
        .ex_addr_i(ex_addr_i), .ex_store_data_i(ex_store_data_i), .ex_wreg_i(ex_wreg_i),
        .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .stall_o(stall_o), .wb_valid_o(wb_valid_o), .wb_wreg_o(wb_wreg_o),
        .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o), .mem_err_o(mem_err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk = ~clk;

    // Drives one instruction at a negedge, plays the bus slave (ack on request cycle
    // number wait_n, counting from 0), and checks the whole transaction against the model.
    task automatic run_op(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] st, input logic wreg, input logic [4:0] waddr,
                          input logic [31:0] wdata, input int wait_n, input logic [31:0] rdata);
        bit          ls, word, store, mis, err, done;
        int          exp_stall, exp_req, stall_cnt, req_cnt, n, off;
        logic [3:0]  exp_be;
        logic [31:0] exp_bwdata, exp_wdata, byte_val;
        logic        exp_wreg;

        ls    = (sel == 3'd6) && (op >= 8'd10) && (op <= 8'd13);
        word  = (op == 8'd10) || (op == 8'd13);
        store = (op == 8'd12) || (op == 8'd13);
        off   = int'(addr % 4);
        mis   = ls && word && (off != 0);
        exp_stall = (!ls || mis) ? 0 : ((wait_n < TMO) ? wait_n + 1 : TMO);
        exp_req   = exp_stall;
        err       = mis || (ls && !mis && wait_n >= TMO);
        exp_wreg  = !ls ? wreg : ((err || store) ? 1'b0 : wreg);
        exp_be    = word ? 4'hF : 4'(1 << off);
        exp_bwdata = (op == 8'd12) ? {4{st[7:0]}} : st;
        byte_val  = (rdata >> (8 * off)) & 32'hFF;
        if (!ls)               exp_wdata = wdata;
        else if (op == 8'd10)  exp_wdata = rdata;
        else                   exp_wdata = (byte_val >= 128) ? byte_val - 32'd256 : byte_val;

        ex_valid_i = 1'b1; ex_alu_sel_i = sel; ex_alu_op_i = op; ex_addr_i = addr;
        ex_store_data_i = st; ex_wreg_i = wreg; ex_waddr_i = waddr; ex_wdata_i = wdata;
        n = 0; stall_cnt = 0; req_cnt = 0; done = 1'b0;
        while (!done && n < 40) begin
            if (bus_req_o) begin
                req_cnt++;
                vectors++;
                if ({bus_we_o, bus_addr_o, bus_be_o} !== {store, addr[31:2], 2'b00, exp_be}) begin
                    errs++;
                    $display("FAIL bus_fields txn %0d: got we=%0b addr=%h be=%b, want we=%0b addr=%h be=%b",
                             txn, bus_we_o, bus_addr_o, bus_be_o, store, {addr[31:2], 2'b00}, exp_be);
                end
                if (store) begin
                    vectors++;
                    if (bus_wdata_o !== exp_bwdata) begin
                        errs++;
                        $display("FAIL bus_wdata txn %0d: got %h want %h", txn, bus_wdata_o, exp_bwdata);
                    end
                end
                bus_ack_i   = (req_cnt - 1 == wait_n);
                bus_rdata_i = bus_ack_i ? rdata : $urandom;
            end else begin
                bus_ack_i   = 1'($urandom_range(0, 1));
                bus_rdata_i = $urandom;
            end
            if (n > 0) begin
                vectors++;
                if (wb_valid_o !== 1'b0) begin
                    errs++;
                    $display("FAIL wb_valid_busy txn %0d: got %0b want 0", txn, wb_valid_o);
                end
            end
            #1;
            if (stall_o) stall_cnt++; else done = 1'b1;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        ex_valid_i = 1'b0; bus_ack_i = 1'b0;
        #1;
        vectors++;
        if (!done) begin
            errs++;
            $display("FAIL stall_bound txn %0d: stall still high after %0d cycles, want release", txn, n);
        end
        vectors++;
        if (stall_cnt != exp_stall || req_cnt != exp_req) begin
            errs++;
            $display("FAIL stall_req_cycles txn %0d: got stall=%0d req=%0d want stall=%0d req=%0d",
                     txn, stall_cnt, req_cnt, exp_stall, exp_req);
        end
        vectors++;
        if ({wb_valid_o, mem_err_o, wb_wreg_o, bus_req_o} !== {1'b1, err, exp_wreg, 1'b0}) begin
            errs++;
            $display("FAIL retire_flags txn %0d: got valid=%0b err=%0b wreg=%0b req=%0b want 1 %0b %0b 0",
                     txn, wb_valid_o, mem_err_o, wb_wreg_o, bus_req_o, err, exp_wreg);
        end
        if (exp_wreg) begin
            vectors++;
            if (wb_waddr_o !== waddr || wb_wdata_o !== exp_wdata) begin
                errs++;
                $display("FAIL wb_data txn %0d: got waddr=%0d wdata=%h want waddr=%0d wdata=%h",
                         txn, wb_waddr_o, wb_wdata_o, waddr, exp_wdata);
            end
        end
        $display("txn %0d sel=%0d op=%0d addr=%h wait=%0d -> stall=%0d err=%0b wreg=%0b wdata=%h",
                 txn, sel, op, addr, wait_n, stall_cnt, mem_err_o, wb_wreg_o, wb_wdata_o);
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (wb_valid_o !== 1'b0 || mem_err_o !== 1'b0) begin
            errs++;
            $display("FAIL pulse_clear txn %0d: got valid=%0b err=%0b want 0 0", txn, wb_valid_o, mem_err_o);
        end
        txn++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ex_valid_i = 1'b0; ex_alu_sel_i = '0; ex_alu_op_i = '0; ex_addr_i = '0;
        ex_store_data_i = '0; ex_wreg_i = 1'b0; ex_waddr_i = '0; ex_wdata_i = '0;
        bus_ack_i = 1'b0; bus_rdata_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({wb_valid_o, wb_wreg_o, wb_waddr_o, wb_wdata_o, mem_err_o, bus_req_o, bus_we_o,
             bus_addr_o, bus_be_o, bus_wdata_o, stall_o} !== '0) begin
            errs++;
            $display("FAIL reset_state: got valid=%0b req=%0b stall=%0b addr=%h wdata=%h, want all 0",
                     wb_valid_o, bus_req_o, stall_o, bus_addr_o, wb_wdata_o);
        end
        rst_n = 1'b1;
        $display("txn reset done");
    endtask

    task automatic test_passthrough();
        run_op(3'd6, 8'd7, 32'h0, 32'h0, 1'b1, 5'd3, 32'h1234, 0, 32'h0);
        run_op(3'd1, 8'd10, 32'h5, 32'h0, 1'b1, 5'd9, 32'hCAFE_0001, 0, 32'h0);
    endtask

    task automatic test_lb();
        run_op(3'd6, 8'd11, 32'h1003, 32'h0, 1'b1, 5'd4, 32'h0, 2, 32'h80FF_FFFF);
        run_op(3'd6, 8'd11, 32'h1001, 32'h0, 1'b1, 5'd5, 32'h0, 0, 32'h1234_7F56);
    endtask

    task automatic test_sb();
        run_op(3'd6, 8'd12, 32'h2001, 32'hAB, 1'b1, 5'd6, 32'h0, 1, 32'h0);
    endtask

    task automatic test_misaligned();
        run_op(3'd6, 8'd10, 32'h2002, 32'h0, 1'b1, 5'd7, 32'h0, 0, 32'h0);
        run_op(3'd6, 8'd13, 32'h2003, 32'h55, 1'b0, 5'd0, 32'h0, 0, 32'h0);
    endtask

    task automatic test_timeout();
        run_op(3'd6, 8'd13, 32'h3000, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 99, 32'h0);
        run_op(3'd6, 8'd10, 32'h3004, 32'h0, 1'b1, 5'd8, 32'h0, TMO - 1, 32'h1357_9BDF);
    endtask

    task automatic test_reset_busy();
        ex_valid_i = 1'b1; ex_alu_sel_i = 3'd6; ex_alu_op_i = 8'd10; ex_addr_i = 32'h4000;
        ex_wreg_i = 1'b1; ex_waddr_i = 5'd10; bus_ack_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus_req_o !== 1'b1) begin
            errs++;
            $display("FAIL busy_req: got %0b want 1", bus_req_o);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus_req_o !== 1'b0 || wb_valid_o !== 1'b0) begin
            errs++;
            $display("FAIL reset_abort: got req=%0b valid=%0b want 0 0", bus_req_o, wb_valid_o);
        end
        rst_n = 1'b1; ex_valid_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h7777_7777;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (bus_req_o !== 1'b0 || wb_valid_o !== 1'b0 || stall_o !== 1'b0) begin
                errs++;
                $display("FAIL late_ack: got req=%0b valid=%0b stall=%0b want 0 0 0",
                         bus_req_o, wb_valid_o, stall_o);
            end
        end
        bus_ack_i = 1'b0;
        $display("txn reset-in-busy done");
    endtask

    task automatic test_random();
        logic [7:0] ops [6];
        logic [7:0] op;
        logic [2:0] sel;
        ops[0] = 8'd7; ops[1] = 8'd10; ops[2] = 8'd11; ops[3] = 8'd12; ops[4] = 8'd13; ops[5] = 8'd14;
        for (int i = 0; i < 40; i++) begin
            op  = ops[$urandom_range(0, 5)];
            sel = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd6;
            run_op(sel, op, $urandom, $urandom, 1'($urandom), 5'($urandom), $urandom,
                   $urandom_range(0, TMO + 1), $urandom);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_passthrough();
        test_lb();
        test_sb();
        test_misaligned();
        test_timeout();
        test_reset_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
